// File: rtl/debounce_defs.sv
// -----------------------------------------------------------------------------
// debounce_defs
// Shared definitions for the debounce_sync block:
//   - 2-bit FSM state encodings (stable low/high, waiting to go high/low)
//   - default qualification length for a level change
// Bit 1 of each encoding equals the debounced level held in that state.
// -----------------------------------------------------------------------------
package debounce_defs;

   localparam logic [1:0] S_LOW  = 2'b00;  // Q=0, input agrees
   localparam logic [1:0] W_HIGH = 2'b01;  // Q=0, qualifying a rise
   localparam logic [1:0] S_HIGH = 2'b11;  // Q=1, input agrees
   localparam logic [1:0] W_LOW  = 2'b10;  // Q=1, qualifying a fall

   localparam int DEF_STABLE_CYCLES = 16;

endpackage : debounce_defs

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser that brings one asynchronous bit into the clk domain.
// Ports:
//   clk      in  : destination clock
//   rst_n    in  : asynchronous active-low reset, both flops clear to 0
//   i_async  in  : raw asynchronous input
//   o_sync   out : synchronised copy, two clk edges of latency
// -----------------------------------------------------------------------------
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_sync
);

   logic r_s1;
   logic r_s2;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour; blocking here would collapse
   // the two stages into one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_async;
         r_s2 <= r_s1;
      end
   end

   assign o_sync = r_s2;

endmodule : sync_2ff

// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
// Turns a bouncing asynchronous input (button, switch) into a clean level.
// The input is synchronised, then a counter-based FSM requires it to differ
// from the current level for STABLE_CYCLES consecutive samples before the
// level flips. Any reversion during qualification restarts from scratch.
// Parameters:
//   STABLE_CYCLES : consecutive samples needed to accept a change (>= 2)
//   CNT_W         : counter width, 2**CNT_W > STABLE_CYCLES
// Ports:
//   clk    in  : single clock, all state on posedge
//   rst_n  in  : asynchronous active-low reset
//   D_in   in  : raw asynchronous input
//   Q      out : debounced level (registered)
//   Qb     out : complement of Q, its own register
//   rise   out : one-cycle strobe when Q goes 0->1
//   fall   out : one-cycle strobe when Q goes 1->0
//   busy   out : high while a candidate change is being qualified
// -----------------------------------------------------------------------------
module debounce_sync
   import debounce_defs::*;
#(
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int CNT_W         = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic D_in,
   output logic Q,
   output logic Qb,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

   logic             w_sync;
   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;

   sync_2ff u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (D_in),
      .o_sync  (w_sync)
   );

   // The sample that moves the FSM into a WAIT state is the first qualifying
   // sample, so the counter starts at 1 and the change is accepted on the
   // sample that finds it at STABLE_CYCLES-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_LOW;
         r_cnt   <= '0;
         Q       <= 1'b0;
         Qb      <= 1'b1;
         rise    <= 1'b0;
         fall    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         // Strobes last exactly one cycle unless re-asserted below.
         rise <= 1'b0;
         fall <= 1'b0;
         case (r_state)
            S_LOW: begin
               if (w_sync) begin
                  r_state <= W_HIGH;
                  r_cnt   <= LP_CNT_ONE;
                  busy    <= 1'b1;
               end
            end
            W_HIGH: begin
               if (!w_sync) begin
                  r_state <= S_LOW;
                  r_cnt   <= '0;
                  busy    <= 1'b0;
               end else if (r_cnt == LP_CNT_LAST) begin
                  r_state <= S_HIGH;
                  r_cnt   <= '0;
                  busy    <= 1'b0;
                  Q       <= 1'b1;
                  Qb      <= 1'b0;
                  rise    <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + LP_CNT_ONE;
               end
            end
            S_HIGH: begin
               if (!w_sync) begin
                  r_state <= W_LOW;
                  r_cnt   <= LP_CNT_ONE;
                  busy    <= 1'b1;
               end
            end
            W_LOW: begin
               if (w_sync) begin
                  r_state <= S_HIGH;
                  r_cnt   <= '0;
                  busy    <= 1'b0;
               end else if (r_cnt == LP_CNT_LAST) begin
                  r_state <= S_LOW;
                  r_cnt   <= '0;
                  busy    <= 1'b0;
                  Q       <= 1'b0;
                  Qb      <= 1'b1;
                  fall    <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + LP_CNT_ONE;
               end
            end
            default: begin
               r_state <= S_LOW;
               r_cnt   <= '0;
               busy    <= 1'b0;
               Q       <= 1'b0;
               Qb      <= 1'b1;
            end
         endcase
      end
   end

endmodule : debounce_sync
